// File: rtl/d_reg_pkg.sv
// Shared mode encodings and sizing helper for the d_reg_bank register bank.
package d_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  // Channel-select width; a single-channel bank still gets a 1-bit select.
  function automatic int calc_sel_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/d_reg_cell.sv
// One WIDTH-bit channel: sync reset, clear, load and shift-in, in that priority.
// CHANGE_DET_EN adds a registered "value changed" flag output.
module d_reg_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  input  logic             shin,
`ifdef CHANGE_DET_EN
  output logic             changed,
`endif
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] nxt;

  generate
    if (WIDTH > 1) begin : g_wide
      assign shifted = {q[WIDTH-2:0], shin};
    end else begin : g_bit
      assign shifted = shin;
    end
  endgenerate

  always_comb begin
    nxt = q;
    if (clr) begin
      nxt = '0;
    end else if (load) begin
      nxt = d;
    end else if (shift) begin
      nxt = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

`ifdef CHANGE_DET_EN
  // Compare against the value about to be stored, so an identical write is silent.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      changed <= 1'b0;
    end else begin
      changed <= (nxt != q);
    end
  end
`endif

endmodule

// File: rtl/d_reg_bank.sv
// CHANNELS x WIDTH register bank with per-channel load/clear and a bank-wide shift chain.
// Optional feature macro: CHANGE_DET_EN (per-channel change pulse on chg).
module d_reg_bank
  import d_reg_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = calc_sel_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          ch_sel,
  input  logic [WIDTH-1:0]          d,
  input  logic                      ser_in,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] qb,
  output logic                      ser_out,
  output logic [CHANNELS-1:0]       chg
);

  logic op_load;
  logic op_clear;
  logic op_shift;

  always_comb begin
    op_load  = 1'b0;
    op_clear = 1'b0;
    op_shift = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_LOAD:  op_load  = 1'b1;
        MODE_CLEAR: op_clear = 1'b1;
        MODE_SHIFT: op_shift = 1'b1;
        default:    ;
      endcase
    end
  end

  logic [WIDTH-1:0] ch_q [CHANNELS];

  // An out-of-range ch_sel matches no channel, so LOAD/CLEAR fall through to hold.
  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic hit;
      logic shin;

      assign hit = (ch_sel == SEL_W'(k));

      if (k == 0) begin : g_head
        assign shin = ser_in;
      end else begin : g_link
        assign shin = ch_q[k-1][WIDTH-1];
      end

      d_reg_cell #(
        .WIDTH(WIDTH)
      ) u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (op_clear & hit),
        .load    (op_load & hit),
        .shift   (op_shift),
        .d       (d),
        .shin    (shin),
`ifdef CHANGE_DET_EN
        .changed (chg[k]),
`endif
        .q       (ch_q[k])
      );

      assign q[k*WIDTH +: WIDTH] = ch_q[k];
    end
  endgenerate

`ifndef CHANGE_DET_EN
  assign chg = '0;
`endif

  assign qb      = ~q;
  assign ser_out = q[CHANNELS*WIDTH-1];

endmodule

// File: tb/tb_d_reg_bank.sv
// Self-checking bench for d_reg_bank (4x8 main instance plus a 3x8 instance for out-of-range ch_sel).
module tb_d_reg_bank;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_LOAD  = 2'b01;
  localparam logic [1:0] M_SHIFT = 2'b10;
  localparam logic [1:0] M_CLEAR = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [1:0]  ch_sel = 2'b00;
  logic [7:0]  d = 8'h00;
  logic        ser_in = 1'b0;

  logic [31:0] q, qb;
  logic        ser_out;
  logic [3:0]  chg;
  logic [23:0] q3, qb3;
  logic        ser_out3;
  logic [2:0]  chg3;

  int checks = 0;
  int failures = 0;

  // Reference model: the bank seen as one wide word per instance.
  logic [31:0] m4 = '0;
  logic [23:0] m3 = '0;
  logic [31:0] exp_q[$];
  logic [3:0]  exp_chg;
  logic [2:0]  exp_chg3;

  always #5 clk = ~clk;

  d_reg_bank #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .ch_sel(ch_sel),
    .d(d), .ser_in(ser_in), .q(q), .qb(qb), .ser_out(ser_out), .chg(chg)
  );

  d_reg_bank #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .ch_sel(ch_sel),
    .d(d), .ser_in(ser_in), .q(q3), .qb(qb3), .ser_out(ser_out3), .chg(chg3)
  );

  // Drive one clock of stimulus and advance the model; outputs settle #1 after the edge.
  task automatic cycle(input logic rn, input logic e, input logic [1:0] m,
                       input logic [1:0] s, input logic [7:0] dd, input logic si);
    logic [31:0] n4;
    logic [23:0] n3;
    @(negedge clk);
    reset_n = rn; en = e; mode = m; ch_sel = s; d = dd; ser_in = si;
    n4 = m4;
    n3 = m3;
    if (!rn) begin
      n4 = '0;
      n3 = '0;
    end else if (e) begin
      if (m == M_LOAD) begin
        n4[s*8 +: 8] = dd;
        if (s < 3) n3[s*8 +: 8] = dd;
      end else if (m == M_CLEAR) begin
        n4[s*8 +: 8] = 8'h00;
        if (s < 3) n3[s*8 +: 8] = 8'h00;
      end else if (m == M_SHIFT) begin
        n4 = {m4[30:0], si};
        n3 = {m3[22:0], si};
      end
    end
    exp_chg  = '0;
    exp_chg3 = '0;
`ifdef CHANGE_DET_EN
    for (int k = 0; k < 4; k++) exp_chg[k] = rn && (n4[k*8 +: 8] != m4[k*8 +: 8]);
    for (int k = 0; k < 3; k++) exp_chg3[k] = rn && (n3[k*8 +: 8] != m3[k*8 +: 8]);
`endif
    m4 = n4;
    m3 = n3;
    exp_q.push_back(n4);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    cycle(1'b0, 1'b1, M_LOAD, 2'd0, 8'hFF, 1'b1);
    e = exp_q.pop_front();
    checks++; if (q !== 32'h0 || q !== e) begin failures++; $display("FAIL reset_q got=%h exp=%h", q, e); end
    checks++; if (qb !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_qb got=%h exp=ffffffff", qb); end
    checks++; if (ser_out !== 1'b0) begin failures++; $display("FAIL reset_ser_out got=%b exp=0", ser_out); end
    checks++; if (chg !== 4'b0) begin failures++; $display("FAIL reset_chg got=%b exp=0000", chg); end
    checks++; if (q3 !== 24'h0) begin failures++; $display("FAIL reset_q3 got=%h exp=000000", q3); end
  endtask

  task automatic test_load_hold();
    logic [31:0] e;
    cycle(1'b1, 1'b1, M_LOAD, 2'd2, 8'hA5, 1'b0);
    e = exp_q.pop_front();
    checks++; if (q !== e) begin failures++; $display("FAIL load_q got=%h exp=%h", q, e); end
    checks++; if (chg !== exp_chg) begin failures++; $display("FAIL load_chg got=%b exp=%b", chg, exp_chg); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, M_LOAD, 2'd2, 8'h3C, 1'b0);
      e = exp_q.pop_front();
      checks++; if (q !== e || q !== 32'h00A5_0000) begin failures++; $display("FAIL hold_q[%0d] got=%h exp=%h", i, q, e); end
      checks++; if (chg !== 4'b0) begin failures++; $display("FAIL hold_chg[%0d] got=%b exp=0000", i, chg); end
      checks++; if (qb !== ~e) begin failures++; $display("FAIL hold_qb[%0d] got=%h exp=%h", i, qb, ~e); end
    end
  endtask

  task automatic test_clear();
    logic [31:0] e;
    logic [31:0] pat;
    pat = 32'h1122_3344;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b1, M_LOAD, 2'(k), pat[k*8 +: 8], 1'b0);
      void'(exp_q.pop_front());
    end
    checks++; if (q !== 32'h1122_3344) begin failures++; $display("FAIL clear_setup got=%h exp=11223344", q); end
    cycle(1'b1, 1'b1, M_CLEAR, 2'd1, 8'hEE, 1'b0);
    e = exp_q.pop_front();
    checks++; if (q !== e || q !== 32'h1122_0044) begin failures++; $display("FAIL clear_ch1 got=%h exp=%h", q, e); end
    checks++; if (q3 !== m3) begin failures++; $display("FAIL clear_ch1_q3 got=%h exp=%h", q3, m3); end
    checks++; if (chg !== exp_chg) begin failures++; $display("FAIL clear_chg got=%b exp=%b", chg, exp_chg); end
    // ch_sel=3 is out of range for the 3-channel bank: no change, no pulse.
    cycle(1'b1, 1'b1, M_CLEAR, 2'd3, 8'h00, 1'b0);
    e = exp_q.pop_front();
    checks++; if (q3 !== 24'h22_0044) begin failures++; $display("FAIL clear_oob_q3 got=%h exp=220044", q3); end
    checks++; if (chg3 !== 3'b0) begin failures++; $display("FAIL clear_oob_chg3 got=%b exp=000", chg3); end
    checks++; if (q !== e) begin failures++; $display("FAIL clear_ch3_q got=%h exp=%h", q, e); end
    cycle(1'b1, 1'b1, M_LOAD, 2'd3, 8'h99, 1'b0);
    void'(exp_q.pop_front());
    checks++; if (q3 !== 24'h22_0044) begin failures++; $display("FAIL load_oob_q3 got=%h exp=220044", q3); end
  endtask

  task automatic test_shift();
    logic [31:0] e;
    cycle(1'b0, 1'b0, M_HOLD, 2'd0, 8'h00, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 1; i <= 32; i++) begin
      cycle(1'b1, 1'b1, M_SHIFT, 2'($urandom_range(0, 3)), 8'($urandom), 1'b1);
      e = exp_q.pop_front();
      checks++; if (q !== e) begin failures++; $display("FAIL shift_q[%0d] got=%h exp=%h", i, q, e); end
      checks++; if (ser_out !== e[31]) begin failures++; $display("FAIL shift_ser_out[%0d] got=%b exp=%b", i, ser_out, e[31]); end
      checks++; if (chg !== exp_chg) begin failures++; $display("FAIL shift_chg[%0d] got=%b exp=%b", i, chg, exp_chg); end
      if (i == 9) begin
        checks++; if (q !== 32'h0000_01FF) begin failures++; $display("FAIL shift9 got=%h exp=000001ff", q); end
      end
    end
    checks++; if (ser_out !== 1'b1) begin failures++; $display("FAIL shift32_ser_out got=%b exp=1", ser_out); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] e;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, M_SHIFT, 2'd0, 8'h00, 1'($urandom));
      void'(exp_q.pop_front());
    end
    cycle(1'b0, 1'b1, M_SHIFT, 2'd0, 8'h00, 1'b1);
    e = exp_q.pop_front();
    checks++; if (q !== 32'h0 || q !== e) begin failures++; $display("FAIL midreset_q got=%h exp=00000000", q); end
    checks++; if (chg !== 4'b0) begin failures++; $display("FAIL midreset_chg got=%b exp=0000", chg); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, M_SHIFT, 2'd0, 8'h00, 1'b1);
      e = exp_q.pop_front();
      checks++; if (q !== e) begin failures++; $display("FAIL resume_q[%0d] got=%h exp=%h", i, q, e); end
    end
    checks++; if (q !== 32'h0000_0007) begin failures++; $display("FAIL resume_final got=%h exp=00000007", q); end
  endtask

  task automatic test_change_det();
    logic [31:0] e;
    cycle(1'b1, 1'b1, M_LOAD, 2'd0, 8'h5A, 1'b0);
    e = exp_q.pop_front();
    checks++; if (q !== e) begin failures++; $display("FAIL chg_load1_q got=%h exp=%h", q, e); end
    checks++; if (chg !== exp_chg) begin failures++; $display("FAIL chg_load1 got=%b exp=%b", chg, exp_chg); end
    cycle(1'b1, 1'b1, M_LOAD, 2'd0, 8'h5A, 1'b0);
    void'(exp_q.pop_front());
    checks++; if (chg !== 4'b0) begin failures++; $display("FAIL chg_load2 got=%b exp=0000", chg); end
    cycle(1'b1, 1'b1, M_HOLD, 2'd0, 8'h00, 1'b0);
    void'(exp_q.pop_front());
    checks++; if (chg !== 4'b0) begin failures++; $display("FAIL chg_idle got=%b exp=0000", chg); end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom));
      e = exp_q.pop_front();
      checks++; if (q !== e) begin failures++; $display("FAIL rand_q[%0d] got=%h exp=%h", i, q, e); end
      checks++; if (qb !== ~e) begin failures++; $display("FAIL rand_qb[%0d] got=%h exp=%h", i, qb, ~e); end
      checks++; if (ser_out !== e[31]) begin failures++; $display("FAIL rand_ser_out[%0d] got=%b exp=%b", i, ser_out, e[31]); end
      checks++; if (chg !== exp_chg) begin failures++; $display("FAIL rand_chg[%0d] got=%b exp=%b", i, chg, exp_chg); end
      checks++; if (q3 !== m3) begin failures++; $display("FAIL rand_q3[%0d] got=%h exp=%h", i, q3, m3); end
      checks++; if (chg3 !== exp_chg3) begin failures++; $display("FAIL rand_chg3[%0d] got=%b exp=%b", i, chg3, exp_chg3); end
    end
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_clear();
    test_shift();
    test_reset_mid_op();
    test_change_det();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
